uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8N1 UART: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity.
- Parallel load/unload interface on the host side, serial tx_out/rx_in on the line side.
- Sits between a host register interface and the board pins.
- Single clock domain; bit timing comes from an internal divide-by-CLKS_PER_BIT counter.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8; not user-changeable.

Ports:
- txclk  input  1  the single clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rxclk  input  1  kept for pinout compatibility only; unused internally; tied to txclk at top level.
- ld_tx_data  input  1  load tx_data into the transmit holding register.
- tx_data  input  8  byte to transmit.
- tx_enable  input  1  allows the transmitter to advance.
- tx_out  output  1  serial line out; idles high.
- tx_empty  output  1  1 = transmitter idle and able to accept a load.
- uld_rx_data  input  1  host acknowledges/unloads the received byte.
- rx_data  output  8  last received byte.
- rx_enable  input  1  enables the receiver.
- rx_in  input  1  serial line in; asynchronous.
- rx_empty  output  1  1 = no unread received byte.

Behaviour:
- Reset (synchronous, txclk edge with reset=1): tx_out=1, tx_empty=1, rx_data=0x00, rx_empty=1. All counters and FSMs go to IDLE. Reset mid-frame aborts the frame immediately.
- TX FSM states: IDLE, START, DATA, STOP.
  - ld_tx_data=1 while tx_empty=1: capture tx_data; tx_empty=0 from the next cycle.
  - ld_tx_data while tx_empty=0: ignored; the in-flight byte is unaffected.
  - With tx_enable=1 and a byte loaded: tx_out=0 (START) starting the cycle after the load.
  - Each bit is held exactly CLKS_PER_BIT cycles: START, then D0..D7, then STOP (tx_out=1).
  - At the end of the STOP period: tx_empty=1 and FSM returns to IDLE. Frame length is 10*CLKS_PER_BIT cycles.
  - tx_enable=0 mid-frame: baud and bit counters freeze and tx_out holds its current level; transmission resumes when tx_enable returns to 1.
  - tx_enable=0 with a byte loaded but not started: byte waits, tx_out=1.
- RX path:
  - rx_in passes through a 2-flop synchronizer; all RX timing refers to the synchronized signal.
  - rx_enable=0: RX FSM forced to IDLE and the line is ignored. rx_data and rx_empty hold their values, and uld_rx_data still works.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on synchronized line = 0.
  - After CLKS_PER_BIT/2 cycles, resample: 0 means a valid start; 1 means a glitch, return to IDLE.
  - Then sample each data bit every CLKS_PER_BIT cycles (mid-bit), LSB first.
  - STOP sample = 1: rx_data <= shifted byte and rx_empty <= 0 on the same edge.
  - STOP sample = 0: framing error; byte discarded, rx_data/rx_empty unchanged.
  - FSM returns to IDLE right after the stop sample, so back-to-back frames are accepted.
- uld_rx_data=1: rx_empty=1 next cycle; rx_data retains its value.
- Overrun: a new byte completing while rx_empty=0 overwrites rx_data; rx_empty stays 0.
- uld_rx_data in the same cycle as a byte completing: the new byte wins, rx_empty=0.
- TX and RX are fully independent and can operate simultaneously.

Decomposition:
- Package uart_pkg holds:
  - CLKS_PER_BIT default, DATA_BITS
  - the shared FSM state enum (IDLE, START, DATA, STOP)
  - START_BIT=0, STOP_BIT=1 constants
- One natural sub-module: uart_sync2, the 2-flop synchronizer for rx_in.
- TX and RX FSMs stay in uart_core.

Test Plan:
- Reset: hold reset 3 cycles -> tx_out=1, tx_empty=1, rx_empty=1, rx_data=0x00; rx_in=0 with rx_enable=0 -> rx_empty stays 1.
- TX frame: tx_enable=1, load 0xA5 -> tx_empty=0 next cycle. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_empty=1 after 160 cycles.
- Loopback: tie tx_out to rx_in, rx_enable=1, send 0x3C -> rx_data=0x3C and rx_empty=0. Pulse uld_rx_data -> rx_empty=1, rx_data stays 0x3C.
- Load while busy plus tx_enable pause:
  - ld_tx_data with 0xFF mid-frame of 0x00 -> line still shows 0x00.
  - Drop tx_enable for 20 cycles mid-DATA -> current bit stretched by 20 cycles, rest of frame unchanged.
- Error cases:
  - 4-cycle low glitch on rx_in -> no byte.
  - Frame 0x55 with stop bit 0 -> rx_empty stays 1.
- Overrun: two loopback bytes 0x11 then 0x22 with no unload -> rx_data=0x22, rx_empty=0. uld_rx_data coincident with completion of 0x22 -> rx_empty=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the 8N1 UART core.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS        = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the idle (high) level.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: parallel host side, serial line side, one clock domain.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 txclk,
  input  logic                 reset,
  input  logic                 rxclk,
  input  logic                 ld_tx_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 tx_empty,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  output logic                 rx_empty
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // rxclk only exists for pinout compatibility
  logic unused_rxclk;
  assign unused_rxclk = rxclk;

  uart_state_e          tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shift;

  uart_state_e          rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_s;

  uart_sync2 u_rx_sync (
    .clk   (txclk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  // Transmitter: tx_enable=0 freezes the bit timing and holds the line level.
  always_ff @(posedge txclk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_out   <= STOP_BIT;
      tx_empty <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (ld_tx_data && tx_empty) begin
            tx_shift <= tx_data;
            tx_empty <= 1'b0;
          end
          if ((ld_tx_data || !tx_empty) && tx_enable) begin
            tx_state <= START;
            tx_out   <= START_BIT;
            tx_cnt   <= '0;
          end
        end
        START: begin
          if (tx_enable) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_idx   <= '0;
              tx_state <= DATA;
              tx_out   <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tx_enable) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt <= '0;
              if (tx_idx == IDX_LAST) begin
                tx_state <= STOP;
                tx_out   <= STOP_BIT;
              end else begin
                tx_idx   <= tx_idx + IDX_W'(1);
                tx_out   <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              end
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tx_enable) begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_state <= IDLE;
              tx_empty <= 1'b1;
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // Receiver: mid-bit sampling; a completing byte overrides a same-cycle unload.
  always_ff @(posedge txclk) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_empty <= 1'b1;
    end else begin
      if (uld_rx_data) begin
        rx_empty <= 1'b1;
      end
      if (!rx_enable) begin
        rx_state <= IDLE;
        rx_cnt   <= '0;
      end else begin
        case (rx_state)
          IDLE: begin
            if (rx_s == START_BIT) begin
              rx_state <= START;
              rx_cnt   <= '0;
            end
          end
          START: begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt   <= '0;
              rx_idx   <= '0;
              rx_state <= (rx_s == START_BIT) ? DATA : IDLE;
            end else begin
              rx_cnt <= rx_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == IDX_LAST) begin
                rx_state <= STOP;
              end else begin
                rx_idx <= rx_idx + IDX_W'(1);
              end
            end else begin
              rx_cnt <= rx_cnt + CNT_W'(1);
            end
          end
          STOP: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_state <= IDLE;
              if (rx_s == STOP_BIT) begin
                rx_data  <= rx_shift;
                rx_empty <= 1'b0;
              end
            end else begin
              rx_cnt <= rx_cnt + CNT_W'(1);
            end
          end
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: line-level TX model and byte-level RX model.
module tb_uart_core;

  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;

  logic       txclk = 1'b0;
  logic       reset;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_out;
  logic       tx_empty;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_enable;
  logic       rx_in;
  logic       rx_empty;

  logic       loop;
  logic       rx_drv;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference receiver state
  logic [7:0] exp_data;
  logic       exp_empty;

  assign rx_in = loop ? tx_out : rx_drv;

  always #5 txclk = ~txclk;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .txclk       (txclk),
    .reset       (reset),
    .rxclk       (txclk),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_enable   (tx_enable),
    .tx_out      (tx_out),
    .tx_empty    (tx_empty),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .rx_empty    (rx_empty)
  );

  // Level of bit slot k (0=start, 1..8=data LSB first, 9=stop) of an 8N1 frame
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Load a byte and check the line cycle by cycle against the ideal waveform.
  task automatic tx_run(input logic [7:0] b, input int pre_wait, input int pause_at,
                        input int pause_len, input int busy_at, input string tag);
    logic exp_q[$];
    logic lv;
    for (int c = 0; c < FRAME; c++) exp_q.push_back(frame_bit(b, c / CPB));
    if (pause_len > 0) begin
      lv = exp_q[pause_at];
      for (int k = 0; k < pause_len; k++) exp_q.insert(pause_at + 1, lv);
    end
    @(negedge txclk);
    tx_data    = b;
    ld_tx_data = 1'b1;
    tx_enable  = (pre_wait == 0);
    @(negedge txclk);
    ld_tx_data = 1'b0;
    tx_data    = 8'($urandom);
    n_cmp++;
    if (tx_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL %s tx_empty after load: got %b expected 0", tag, tx_empty);
    end
    if (pre_wait > 0) begin
      for (int k = 0; k < pre_wait; k++) begin
        n_cmp++;
        if (tx_out !== 1'b1 || tx_empty !== 1'b0) begin
          n_bad++;
          $display("FAIL %s waiting byte cycle %0d: tx_out=%b tx_empty=%b expected 1/0",
                   tag, k, tx_out, tx_empty);
        end
        @(negedge txclk);
      end
      tx_enable = 1'b1;
      @(negedge txclk);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (tx_out !== exp_q[i] || tx_empty !== 1'b0) begin
        n_bad++;
        $display("FAIL %s line cycle %0d: tx_out=%b tx_empty=%b expected %b/0",
                 tag, i, tx_out, tx_empty, exp_q[i]);
      end
      ld_tx_data = (i == busy_at);
      if (i == busy_at) tx_data = 8'hFF;
      if (pause_len > 0 && i == pause_at) tx_enable = 1'b0;
      if (pause_len > 0 && i == pause_at + pause_len) tx_enable = 1'b1;
      @(negedge txclk);
    end
    ld_tx_data = 1'b0;
    n_cmp++;
    if (tx_empty !== 1'b1 || tx_out !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end of frame: tx_empty=%b tx_out=%b expected 1/1", tag, tx_empty, tx_out);
    end
  endtask

  // Drive one raw frame on rx_in; uld_rx_data is pulsed in cycle uld_at (-1 = never).
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int uld_at);
    for (int i = 0; i < FRAME; i++) begin
      rx_drv      = (i / CPB == 9) ? stop : frame_bit(b, i / CPB);
      uld_rx_data = (i == uld_at);
      @(negedge txclk);
    end
    uld_rx_data = 1'b0;
    rx_drv      = 1'b1;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    @(negedge txclk);
    uld_rx_data = 1'b0;
    exp_empty   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; loop = 1'b0; rx_drv = 1'b0; rx_enable = 1'b0;
    tx_enable = 1'b0; ld_tx_data = 1'b0; tx_data = 8'h00; uld_rx_data = 1'b0;
    repeat (3) @(negedge txclk);
    exp_data = 8'h00; exp_empty = 1'b1;
    n_cmp++;
    if (tx_out !== 1'b1 || tx_empty !== 1'b1 || rx_empty !== 1'b1 || rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset: tx_out=%b tx_empty=%b rx_empty=%b rx_data=%h expected 1/1/1/00",
               tx_out, tx_empty, rx_empty, rx_data);
    end
    reset = 1'b0;
    repeat (40) @(negedge txclk);
    n_cmp++;
    if (rx_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_disabled_low_line: rx_empty=%b expected 1", rx_empty);
    end
    rx_drv = 1'b1;
    repeat (5) @(negedge txclk);
    rx_enable = 1'b1;
    repeat (5) @(negedge txclk);
  endtask

  task automatic test_tx_frame();
    tx_run(8'hA5, 0, -1, 0, -1, "tx_a5");
    for (int k = 0; k < 3; k++) tx_run(8'($urandom), 0, -1, 0, -1, "tx_rand");
    tx_run(8'($urandom), 30, -1, 0, -1, "tx_pending");
  endtask

  task automatic test_busy_pause();
    tx_run(8'h00, 0, -1, 0, 50, "tx_busy_load");
    tx_run(8'h5A, 0, 40, 20, -1, "tx_pause");
    for (int k = 0; k < 2; k++)
      tx_run(8'($urandom), 0, $urandom_range(1, FRAME - 2), $urandom_range(1, 30), -1, "tx_pause_rand");
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    loop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      tx_run(b, 0, -1, 0, -1, "loop_tx");
      exp_data = b; exp_empty = 1'b0;
      n_cmp++;
      if (rx_data !== exp_data || rx_empty !== exp_empty) begin
        n_bad++;
        $display("FAIL loopback rx: rx_data=%h rx_empty=%b expected %h/%b",
                 rx_data, rx_empty, exp_data, exp_empty);
      end
      unload();
      n_cmp++;
      if (rx_data !== exp_data || rx_empty !== exp_empty) begin
        n_bad++;
        $display("FAIL loopback unload: rx_data=%h rx_empty=%b expected %h/%b",
                 rx_data, rx_empty, exp_data, exp_empty);
      end
    end
    loop = 1'b0;
  endtask

  task automatic test_rx_errors();
    // short low pulse is a glitch, not a start bit
    rx_drv = 1'b0;
    repeat (4) @(negedge txclk);
    rx_drv = 1'b1;
    repeat (2 * FRAME) @(negedge txclk);
    n_cmp++;
    if (rx_empty !== exp_empty || rx_data !== exp_data) begin
      n_bad++;
      $display("FAIL rx_glitch: rx_empty=%b rx_data=%h expected %b/%h",
               rx_empty, rx_data, exp_empty, exp_data);
    end
    rx_frame(8'h55, 1'b0, -1);
    repeat (40) @(negedge txclk);
    n_cmp++;
    if (rx_empty !== exp_empty || rx_data !== exp_data) begin
      n_bad++;
      $display("FAIL rx_framing: rx_empty=%b rx_data=%h expected %b/%h",
               rx_empty, rx_data, exp_empty, exp_data);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a, b;
    loop = 1'b1;
    tx_run(8'h11, 0, -1, 0, -1, "ovr_tx11");
    tx_run(8'h22, 0, -1, 0, -1, "ovr_tx22");
    loop = 1'b0;
    exp_data = 8'h22; exp_empty = 1'b0;
    n_cmp++;
    if (rx_data !== exp_data || rx_empty !== exp_empty) begin
      n_bad++;
      $display("FAIL overrun: rx_data=%h rx_empty=%b expected %h/%b",
               rx_data, rx_empty, exp_data, exp_empty);
    end
    // back-to-back raw frames, unload lands on the edge where the second completes
    a = 8'($urandom);
    b = 8'($urandom);
    rx_frame(a, 1'b1, -1);
    rx_frame(b, 1'b1, 154);
    exp_data = b; exp_empty = 1'b0;
    repeat (4) @(negedge txclk);
    n_cmp++;
    if (rx_data !== exp_data || rx_empty !== exp_empty) begin
      n_bad++;
      $display("FAIL unload_vs_complete: rx_data=%h rx_empty=%b expected %h/%b",
               rx_data, rx_empty, exp_data, exp_empty);
    end
  endtask

  task automatic test_rx_disable();
    rx_enable = 1'b0;
    rx_frame(~exp_data, 1'b1, -1);
    repeat (10) @(negedge txclk);
    n_cmp++;
    if (rx_data !== exp_data || rx_empty !== exp_empty) begin
      n_bad++;
      $display("FAIL rx_disabled_frame: rx_data=%h rx_empty=%b expected %h/%b",
               rx_data, rx_empty, exp_data, exp_empty);
    end
    unload();
    n_cmp++;
    if (rx_data !== exp_data || rx_empty !== exp_empty) begin
      n_bad++;
      $display("FAIL rx_disabled_unload: rx_data=%h rx_empty=%b expected %h/%b",
               rx_data, rx_empty, exp_data, exp_empty);
    end
    rx_enable = 1'b1;
    repeat (5) @(negedge txclk);
  endtask

  task automatic test_full_duplex();
    logic [7:0] r;
    r = 8'($urandom);
    fork
      tx_run(8'($urandom), 0, -1, 0, -1, "duplex_tx");
      rx_frame(r, 1'b1, -1);
    join
    exp_data = r; exp_empty = 1'b0;
    repeat (4) @(negedge txclk);
    n_cmp++;
    if (rx_data !== exp_data || rx_empty !== exp_empty) begin
      n_bad++;
      $display("FAIL duplex_rx: rx_data=%h rx_empty=%b expected %h/%b",
               rx_data, rx_empty, exp_data, exp_empty);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge txclk);
    tx_data = 8'h00; ld_tx_data = 1'b1; tx_enable = 1'b1;
    @(negedge txclk);
    ld_tx_data = 1'b0;
    repeat (50) @(negedge txclk);
    reset = 1'b1;
    @(negedge txclk);
    reset = 1'b0;
    exp_data = 8'h00; exp_empty = 1'b1;
    n_cmp++;
    if (tx_out !== 1'b1 || tx_empty !== 1'b1 || rx_empty !== exp_empty || rx_data !== exp_data) begin
      n_bad++;
      $display("FAIL reset_midframe: tx_out=%b tx_empty=%b rx_empty=%b rx_data=%h expected 1/1/1/00",
               tx_out, tx_empty, rx_empty, rx_data);
    end
    tx_run(8'($urandom), 0, -1, 0, -1, "tx_after_reset");
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_busy_pause();
    test_loopback();
    test_rx_errors();
    test_overrun();
    test_rx_disable();
    test_full_duplex();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
